// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared constants and types for the fetch stage
package mips_fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_KILL} req_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry in-order queue (OUT + SKID) between instruction memory and decode
module fetch_buf
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic        out_valid,
    output logic        skid_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    fetch_entry_t out_q, skid_q, in_e;
    logic out_free;
    assign in_e     = '{instr: push_instr, pc: push_pc};
    assign out_free = !out_valid || pop;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '{instr: NOP_INSTR, pc: RESET_PC};
            skid_q     <= '{instr: NOP_INSTR, pc: RESET_PC};
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            out_valid  <= skid_valid || push;
            skid_valid <= skid_valid && push;
            if (skid_valid) out_q <= skid_q;
            else if (push) out_q <= in_e;
            if (push) skid_q <= in_e;
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_q     <= in_e;
        end
    end
    assign out_instr = out_valid ? out_q.instr : NOP_INSTR;
    assign out_pc    = out_q.pc;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch with redirect kill
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_nextpc,
    input  logic        i_pcsrc,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);
    req_state_t state, state_nx;
    logic [31:0] fetch_pc, kill_addr;
    logic kill, skid_valid, retire, redirect, ack_ok, push, skid_empty_nx;
    assign retire   = o_valid && !i_stall;
    assign redirect = retire && i_pcsrc;
    assign ack_ok   = i_imem_ack && state == R_BUSY;
    assign push     = ack_ok && !redirect;
    assign skid_empty_nx = redirect || (skid_valid ? retire && !push : !(push && o_valid && !retire));
    always_comb begin
        state_nx    = state;
        o_imem_req  = state != R_IDLE;
        o_imem_addr = kill ? kill_addr : fetch_pc;
        case (state)
            R_IDLE:  state_nx = skid_empty_nx ? R_BUSY : R_IDLE;
            R_BUSY:  state_nx = (redirect && !i_imem_ack) ? R_KILL
                              : (i_imem_ack && !skid_empty_nx) ? R_IDLE : R_BUSY;
            R_KILL:  state_nx = i_imem_ack ? R_BUSY : R_KILL;
            default: state_nx = R_IDLE;
        endcase
    end
    // kill_addr shadows fetch_pc so the stale request address survives a redirect
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= R_IDLE;
            fetch_pc  <= RESET_PC;
            kill_addr <= RESET_PC;
            kill      <= 1'b0;
        end else begin
            state    <= state_nx;
            kill     <= state_nx == R_KILL;
            if (!kill) kill_addr <= fetch_pc;
            fetch_pc <= redirect ? (i_nextpc & ~32'h3) : push ? fetch_pc + PC_INC : fetch_pc;
        end
    end
    fetch_buf #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_buf (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .push_instr (i_imem_data),
        .push_pc    (fetch_pc),
        .pop        (retire),
        .flush      (redirect),
        .out_valid  (o_valid),
        .skid_valid (skid_valid),
        .out_instr  (o_instr),
        .out_pc     (o_pc)
    );
    assign o_pc_plus4 = o_pc + PC_INC;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a retired-stream model
module tb_pc_fetch_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] nextpc = 32'h0, data = 32'h0;
    logic pcsrc = 1'b0, stall = 1'b0, ack = 1'b0;
    logic req, valid;
    logic [31:0] addr, instr, pc, pc4;
    logic w_stall = 1'b0, w_pcsrc = 1'b0, w_ack = 1'b0;
    logic [31:0] w_nextpc = 32'h0, w_data = 32'h0;
    logic w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;
    int checks = 0, failures = 0, retires = 0, lat = 0, max_lat = 0;
    logic auto_mem = 1'b1, pend = 1'b0;
    logic [31:0] pend_addr = 32'h0, exp_pc = 32'h0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .i_clk(clk), .i_rst(rst), .i_nextpc(nextpc), .i_pcsrc(pcsrc), .i_stall(stall),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_data(data),
        .o_valid(valid), .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc4)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) wrap (
        .i_clk(clk), .i_rst(rst), .i_nextpc(w_nextpc), .i_pcsrc(w_pcsrc), .i_stall(w_stall),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(w_ack), .i_imem_data(w_data),
        .o_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .o_pc_plus4(w_pc4)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h1234_5677;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle: memory responder, protocol check, retired-stream scoreboard, then advance.
    task automatic tick;
        if (auto_mem) begin
            ack  = req && lat == 0;
            data = mem(addr);
            if (req) lat = ack ? int'($urandom_range(0, max_lat)) : lat - 1;
        end
        w_ack  = w_req;
        w_data = mem(w_addr);
        if (!rst) begin
            if (pend) begin
                chk1("req_hold", req, 1'b1);
                chk("addr_hold", addr, pend_addr);
            end
            if (valid && !stall) begin
                chk("ret_pc", pc, exp_pc);
                chk("ret_instr", instr, mem(exp_pc));
                chk("ret_pc4", pc4, exp_pc + 32'd4);
                exp_pc = pcsrc ? (nextpc & ~32'h3) : exp_pc + 32'd4;
                retires++;
            end
        end
        pend      = !rst && req && !ack;
        pend_addr = addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_req", req, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_wpc", w_pc, 32'hFFFF_FFF8);
        chk("rst_wpc4", w_pc4, 32'hFFFF_FFFC);
        rst = 1'b0;
        chk1("c0_req", req, 1'b0);
        tick;
        chk1("c1_req", req, 1'b1);
        chk("c1_addr", addr, 32'h0);
        chk("c1_waddr", w_addr, 32'hFFFF_FFF8);
        tick;
        chk("c2_addr", addr, 32'h4);
        chk1("c2_valid", valid, 1'b1);
        chk("c2_pc", pc, 32'h0);
        chk("c2_pc4", pc4, 32'h4);
        chk("c2_waddr", w_addr, 32'hFFFF_FFFC);
        chk("c2_wpc", w_pc, 32'hFFFF_FFF8);
        tick;
        chk("c3_addr", addr, 32'h8);
        chk("c3_pc", pc, 32'h4);
        chk("c3_pc4", pc4, 32'h8);
        chk("c3_waddr", w_addr, 32'h0);
        chk("c3_wpc", w_pc, 32'hFFFF_FFFC);
        chk("c3_wpc4", w_pc4, 32'h0);
        tick;
        chk("c4_pc", pc, 32'h8);
        chk("c4_pc4", pc4, 32'hC);
        chk("c4_addr", addr, 32'hC);
        stall = 1'b1;
        repeat (5) begin
            tick;
            chk1("stall_req", req, 1'b0);
        end
        chk("stall_pc", pc, 32'h8);
        chk1("stall_valid", valid, 1'b1);
        stall = 1'b0;
        tick;
        chk("unstall_pc", pc, 32'hC);
        chk1("unstall_req", req, 1'b1);
        chk("unstall_addr", addr, 32'h10);
        tick;
        chk("unstall_pc2", pc, 32'h10);
        chk("unstall_addr2", addr, 32'h14);
        auto_mem = 1'b0; ack = 1'b0; pcsrc = 1'b1; nextpc = 32'h400;
        tick;
        pcsrc = 1'b0;
        chk1("kill_valid", valid, 1'b0);
        chk("kill_nop", instr, 32'h0);
        chk1("kill_req", req, 1'b1);
        chk("kill_addr", addr, 32'h14);
        ack = 1'b1; data = mem(32'h14);
        tick;
        chk1("killed_valid", valid, 1'b0);
        chk1("redir_req", req, 1'b1);
        chk("redir_addr", addr, 32'h400);
        auto_mem = 1'b1;
        tick;
        chk1("redir_valid", valid, 1'b1);
        chk("redir_pc", pc, 32'h400);
        pcsrc = 1'b1; nextpc = 32'h103;
        tick;
        pcsrc = 1'b0;
        chk1("drop_valid", valid, 1'b0);
        chk1("drop_req", req, 1'b1);
        chk("drop_addr", addr, 32'h100);
        tick;
        chk1("drop_valid2", valid, 1'b1);
        chk("drop_pc", pc, 32'h100);
        chk("drop_addr2", addr, 32'h104);
        auto_mem = 1'b0; ack = 1'b0; pcsrc = 1'b1; nextpc = 32'h800;
        tick;
        pcsrc = 1'b0;
        chk1("k2_req", req, 1'b1);
        chk("k2_addr", addr, 32'h104);
        rst = 1'b1; exp_pc = 32'h0;
        #1;
        chk1("mrst_valid", valid, 1'b0);
        chk1("mrst_req", req, 1'b0);
        chk("mrst_addr", addr, 32'h0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_pc4", pc4, 32'h4);
        tick;
        rst = 1'b0; ack = 1'b1; data = mem(32'h104);
        chk1("late_req", req, 1'b0);
        tick;
        ack = 1'b0;
        chk1("late_valid", valid, 1'b0);
        chk1("post_req", req, 1'b1);
        chk("post_addr", addr, 32'h0);
        auto_mem = 1'b1;
        tick;
        chk1("post_valid", valid, 1'b1);
        chk("post_pc", pc, 32'h0);
        chk("post_instr", instr, mem(32'h0));
        max_lat = 2;
        for (int i = 0; i < 3000; i++) begin
            stall  = $urandom_range(0, 9) < 3;
            pcsrc  = $urandom_range(0, 9) == 0;
            nextpc = $urandom;
            tick;
        end
        stall = 1'b0; pcsrc = 1'b0;
        repeat (10) tick;
        chk1("progress", retires > 300, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
